// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline hazard logic.
//   mdu_state_t   : MDU countdown FSM encoding (RUN / MDU_WAIT)
//   REG_ZERO      : hard-wired zero register, never a hazard source
//   stall_cause_t : which hazard class won the per-cycle priority
//   dest_hits()   : destination-vs-source register compare helper
// -----------------------------------------------------------------------------
package pipeline_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } mdu_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [2:0] {
      NONE    = 3'd0,
      MEMWAIT = 3'd1,
      HILO    = 3'd2,
      BR      = 3'd3,
      LU      = 3'd4
   } stall_cause_t;

   // True when a producer destination feeds a source of the F/D instruction.
   // $0 is excluded because writes to it are discarded.
   function automatic logic dest_hits(input logic [4:0] dest,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
      return (dest != REG_ZERO) && ((dest == rs) || (uses_rt && (dest == rt)));
   endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit_if
// Bundles the pipeline-side signals seen by the hazard detection unit.
// Handshake: none -- every signal is a level, valid in the cycle it is driven;
// the unit answers combinationally in the same cycle (zero detection latency).
//   slave  modport : the hazard unit (reads pipeline status, drives enables)
//   master modport : the pipeline / testbench (drives status, reads enables)
// -----------------------------------------------------------------------------
interface hazard_detection_unit_if;

   logic [4:0] rs_addr_fd;
   logic [4:0] rt_addr_fd;
   logic       uses_rt_fd;
   logic       branch_fd;
   logic       reads_hilo_fd;
   logic       mem_read_dx;
   logic       write_reg_dx;
   logic [4:0] write_reg_addr_dx;
   logic       mdu_start_dx;
   logic       mem_read_xm;
   logic [4:0] write_reg_addr_xm;
   logic       dmem_req_xm;
   logic       dmem_ready;

   logic       pc_write;
   logic       fd_write;
   logic       dx_bubble;
   logic       dx_write;
   logic       xm_write;
   logic       mw_bubble;
   logic       mdu_busy;

   modport slave (
      input  rs_addr_fd, rt_addr_fd, uses_rt_fd, branch_fd, reads_hilo_fd,
      input  mem_read_dx, write_reg_dx, write_reg_addr_dx, mdu_start_dx,
      input  mem_read_xm, write_reg_addr_xm, dmem_req_xm, dmem_ready,
      output pc_write, fd_write, dx_bubble, dx_write, xm_write, mw_bubble,
      output mdu_busy
   );

   modport master (
      output rs_addr_fd, rt_addr_fd, uses_rt_fd, branch_fd, reads_hilo_fd,
      output mem_read_dx, write_reg_dx, write_reg_addr_dx, mdu_start_dx,
      output mem_read_xm, write_reg_addr_xm, dmem_req_xm, dmem_ready,
      input  pc_write, fd_write, dx_bubble, dx_write, xm_write, mw_bubble,
      input  mdu_busy
   );

endinterface

// File: rtl/mdu_countdown.sv
// -----------------------------------------------------------------------------
// mdu_countdown
// Tracks the multi-cycle MDU: after an accepted start, busy stays high for
// exactly MDU_LATENCY cycles. A new start while busy reloads the countdown.
// The counter keeps running through pipeline freezes since the MDU is
// independent of the pipeline registers.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : mult/div accepted into execute this cycle
//   busy      : HI/LO not yet valid (low while rst is high)
//   state     : current FSM state (debug/observation)
// Parameters: MDU_LATENCY (>= 2), CNT_W (2**CNT_W > MDU_LATENCY)
// -----------------------------------------------------------------------------
module mdu_countdown
   import pipeline_pkg::*;
#(
   parameter int MDU_LATENCY = 32,
   parameter int CNT_W       = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output mdu_state_t state
);

   // Loading LATENCY-1 and leaving on the edge where the count is 0 gives
   // LATENCY busy cycles in total.
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LATENCY - 1);

   mdu_state_t       state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         RUN: begin
            if (start) begin
               state_next = MDU_WAIT;
               count_next = LOAD_VAL;
            end
         end
         MDU_WAIT: begin
            if (start) begin
               count_next = LOAD_VAL;
            end else if (count == '0) begin
               state_next = RUN;
            end else begin
               count_next = count - 1'b1;
            end
         end
         default: begin
            state_next = RUN;
            count_next = '0;
         end
      endcase
   end

   assign busy = (state == MDU_WAIT) && !rst;

endmodule

// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
// Stall/bubble generator for the 5-stage F/D/X/M/W pipeline. Catches hazards
// that forwarding cannot cover, in priority order:
//   MEMWAIT (data memory not ready) > HILO (mfhi/mflo behind busy MDU)
//   > BR (ID-stage branch operand in flight) > LU (load-use)
// Ports:
//   clk, rst : clock, synchronous active-high reset (forces all-stall outputs)
//   bus      : hazard_detection_unit_if.slave (pipeline status in, enables out)
//   stall_cycles, lu_events : statistics, only with HAZARD_STATS_EN defined
// Optional feature macro: HAZARD_STATS_EN
// -----------------------------------------------------------------------------
module hazard_detection_unit
   import pipeline_pkg::*;
#(
   parameter int MDU_LATENCY = 32,
   parameter int CNT_W       = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   hazard_detection_unit_if.slave bus
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [15:0]            lu_events
`endif
);

   logic         hit_memwait;
   logic         hit_hilo;
   logic         hit_br;
   logic         hit_lu;
   logic         mdu_accept;
   logic         mdu_busy;
   mdu_state_t   mdu_state;
   stall_cause_t cause;

   // dx_write is 1 in every case except reset and MEMWAIT, so a start is
   // accepted exactly when neither of those holds.
   assign hit_memwait = bus.dmem_req_xm && !bus.dmem_ready;
   assign mdu_accept  = bus.mdu_start_dx && !hit_memwait && !rst;

   // The start term makes an mfhi directly behind a mult stall with no gap.
   assign hit_hilo = bus.reads_hilo_fd && ((mdu_state == MDU_WAIT) || mdu_accept);

   assign hit_br = bus.branch_fd &&
      ((bus.write_reg_dx && dest_hits(bus.write_reg_addr_dx, bus.rs_addr_fd,
                                      bus.rt_addr_fd, bus.uses_rt_fd)) ||
       (bus.mem_read_xm  && dest_hits(bus.write_reg_addr_xm, bus.rs_addr_fd,
                                      bus.rt_addr_fd, bus.uses_rt_fd)));

   assign hit_lu = bus.mem_read_dx && bus.write_reg_dx &&
      dest_hits(bus.write_reg_addr_dx, bus.rs_addr_fd, bus.rt_addr_fd, bus.uses_rt_fd);

   mdu_countdown #(
      .MDU_LATENCY (MDU_LATENCY),
      .CNT_W       (CNT_W)
   ) u_mdu_countdown (
      .clk   (clk),
      .rst   (rst),
      .start (mdu_accept),
      .busy  (mdu_busy),
      .state (mdu_state)
   );

   always_comb begin
      cause = NONE;
      if (!rst) begin
         if (hit_memwait)   cause = MEMWAIT;
         else if (hit_hilo) cause = HILO;
         else if (hit_br)   cause = BR;
         else if (hit_lu)   cause = LU;
      end
   end

   always_comb begin
      bus.pc_write  = 1'b1;
      bus.fd_write  = 1'b1;
      bus.dx_bubble = 1'b0;
      bus.dx_write  = 1'b1;
      bus.xm_write  = 1'b1;
      bus.mw_bubble = 1'b0;
      if (rst) begin
         bus.pc_write  = 1'b0;
         bus.fd_write  = 1'b0;
         bus.dx_bubble = 1'b1;
         bus.dx_write  = 1'b0;
         bus.xm_write  = 1'b0;
         bus.mw_bubble = 1'b1;
      end else begin
         case (cause)
            MEMWAIT: begin
               // Whole pipeline holds; only M/W drains as a bubble.
               bus.pc_write  = 1'b0;
               bus.fd_write  = 1'b0;
               bus.dx_write  = 1'b0;
               bus.xm_write  = 1'b0;
               bus.mw_bubble = 1'b1;
            end
            HILO, BR, LU: begin
               // Hold F/D and PC, push a NOP into D/X, older stages advance.
               bus.pc_write  = 1'b0;
               bus.fd_write  = 1'b0;
               bus.dx_bubble = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.mdu_busy = mdu_busy;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         lu_events    <= '0;
      end else begin
         if (!bus.pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (cause == LU) begin
            lu_events <= lu_events + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detection_unit
// Table of single-cycle vectors followed by hand-written multi-cycle sequences
// (load-use, $0 destination, branch behind load, mult/mfhi, memory wait,
// MDU restart, reset during MDU). DUT built with MDU_LATENCY=4.
// -----------------------------------------------------------------------------
module tb_hazard_detection_unit;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       branch;
      logic       reads_hilo;
      logic       mem_read_dx;
      logic       write_reg_dx;
      logic [4:0] wr_dx;
      logic       mdu_start;
      logic       mem_read_xm;
      logic [4:0] wr_xm;
      logic       dmem_req;
      logic       dmem_ready;
   } in_t;

   typedef struct {
      string      name;
      in_t        in;
      logic [6:0] exp;
   } vec_t;

   // Output vector order: {pc_write, fd_write, dx_bubble, dx_write, xm_write,
   //                       mw_bubble, mdu_busy}
   localparam logic [6:0] NORMAL = 7'b1101100;
   localparam logic [6:0] STALL  = 7'b0011100;
   localparam logic [6:0] FREEZE = 7'b0000010;
   localparam logic [6:0] RESETV = 7'b0010010;
   localparam logic [6:0] BUSY   = 7'b0000001;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [6:0] exp_q[$];
   vec_t tbl[$];
   in_t  idle;

   hazard_detection_unit_if bus ();

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] lu_events;
`endif

   hazard_detection_unit #(
      .MDU_LATENCY (4),
      .CNT_W       (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .lu_events    (lu_events)
`endif
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   function automatic in_t mk_in(input int rs, input int rt, input int uses_rt,
                                 input int br, input int hilo, input int mrd_dx,
                                 input int wen_dx, input int wr_dx, input int start,
                                 input int mrd_xm, input int wr_xm, input int req,
                                 input int rdy);
      in_t v;
      v.rs           = 5'(rs);
      v.rt           = 5'(rt);
      v.uses_rt      = 1'(uses_rt);
      v.branch       = 1'(br);
      v.reads_hilo   = 1'(hilo);
      v.mem_read_dx  = 1'(mrd_dx);
      v.write_reg_dx = 1'(wen_dx);
      v.wr_dx        = 5'(wr_dx);
      v.mdu_start    = 1'(start);
      v.mem_read_xm  = 1'(mrd_xm);
      v.wr_xm        = 5'(wr_xm);
      v.dmem_req     = 1'(req);
      v.dmem_ready   = 1'(rdy);
      return v;
   endfunction

   task automatic drive(input in_t v);
      bus.rs_addr_fd        = v.rs;
      bus.rt_addr_fd        = v.rt;
      bus.uses_rt_fd        = v.uses_rt;
      bus.branch_fd         = v.branch;
      bus.reads_hilo_fd     = v.reads_hilo;
      bus.mem_read_dx       = v.mem_read_dx;
      bus.write_reg_dx      = v.write_reg_dx;
      bus.write_reg_addr_dx = v.wr_dx;
      bus.mdu_start_dx      = v.mdu_start;
      bus.mem_read_xm       = v.mem_read_xm;
      bus.write_reg_addr_xm = v.wr_xm;
      bus.dmem_req_xm       = v.dmem_req;
      bus.dmem_ready        = v.dmem_ready;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [6:0] got);
      logic [6:0] exp;
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (pc,fd,dxb,dxw,xmw,mwb,busy)",
                  name, got, exp);
      end
   endtask

   // One pipeline cycle: drive just after the edge, sample mid-cycle.
   task automatic step(input string name, input in_t v, input logic [6:0] exp,
                       input logic r = 1'b0);
      @(posedge clk);
      #1;
      rst = r;
      drive(v);
      exp_q.push_back(exp);
      #1;
      check(name, {bus.pc_write, bus.fd_write, bus.dx_bubble, bus.dx_write,
                   bus.xm_write, bus.mw_bubble, bus.mdu_busy});
   endtask

`ifdef HAZARD_STATS_EN
   task automatic check_stats(input string name, input logic [31:0] exp_sc,
                              input logic [15:0] exp_lu);
      n_checks++;
      if (stall_cycles !== exp_sc || lu_events !== exp_lu) begin
         n_fail++;
         $display("FAIL %s: stall_cycles=%0d lu_events=%0d expected %0d/%0d",
                  name, stall_cycles, lu_events, exp_sc, exp_lu);
      end
   endtask
`endif

   task automatic add_vec(input string name, input in_t v, input logic [6:0] exp);
      vec_t t;
      t.name = name;
      t.in   = v;
      t.exp  = exp;
      tbl.push_back(t);
   endtask

   // ---------------- test ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle     = '0;
      drive(idle);

      //      name                 rs rt u  br hl md wd wdx st mx wxm rq rd
      add_vec("idle",        mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), NORMAL);
      add_vec("lu_rs",       mk_in(3, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0), STALL);
      add_vec("lu_rt",       mk_in(1, 7, 1, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0), STALL);
      add_vec("lu_rt_unused",mk_in(1, 7, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0), NORMAL);
      add_vec("lu_r0",       mk_in(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), NORMAL);
      add_vec("alu_no_br",   mk_in(4, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0), NORMAL);
      add_vec("br_dx_alu",   mk_in(5, 0, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0), STALL);
      add_vec("br_xm_load",  mk_in(1, 9, 1, 1, 0, 0, 0, 0, 0, 1, 9, 0, 0), STALL);
      add_vec("br_xm_alu",   mk_in(9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 9, 0, 0), NORMAL);
      add_vec("memwait",     mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), FREEZE);
      add_vec("memwait_lu",  mk_in(3, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 0), FREEZE);
      add_vec("memrdy_lu",   mk_in(3, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 1), STALL);
      add_vec("hilo_idle",   mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), NORMAL);
      add_vec("br_r0",       mk_in(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), NORMAL);
      add_vec("memwait_mult",mk_in(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0), FREEZE);
      add_vec("mult_dropped",mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), NORMAL);
      add_vec("mult_mfhi",   mk_in(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), STALL);

      // Reset dominates even with hazards and a start present.
      step("reset_outputs", mk_in(3, 0, 0, 1, 1, 1, 1, 3, 1, 0, 0, 1, 0), RESETV, 1'b1);
`ifdef HAZARD_STATS_EN
      step("post_reset", idle, NORMAL);
      check_stats("stats_reset", 32'd0, 16'd0);
`endif

      foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);

      // Load-use: one stall, then the load is in X/M and the add proceeds.
      step("rst_a", idle, RESETV, 1'b1);
      step("lu_c0", mk_in(3, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0), STALL);
      step("lu_c1", mk_in(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0), NORMAL);
`ifdef HAZARD_STATS_EN
      check_stats("stats_lu", 32'd1, 16'd1);
`endif
      step("lu_c2", idle, NORMAL);

      // Load into $0: never a hazard.
      step("r0_c0", mk_in(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), NORMAL);
      step("r0_c1", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), NORMAL);

      // Branch behind load: stall via D/X, then via X/M, then release.
      step("brlw_c1", mk_in(5, 0, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0), STALL);
      step("brlw_c2", mk_in(5, 0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0), STALL);
      step("brlw_c3", mk_in(5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), NORMAL);

      // mult then mfhi: stall on the start cycle and all 4 busy cycles.
      step("rst_d", idle, RESETV, 1'b1);
      step("mdu_start", mk_in(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), STALL);
      for (int i = 0; i < 4; i++)
         step($sformatf("mdu_busy_%0d", i), mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              STALL | BUSY);
      step("mdu_release", mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), NORMAL);

      // Memory wait masks a load-use for 3 cycles; LU follows for 1 cycle.
      for (int i = 0; i < 3; i++)
         step($sformatf("mw_freeze_%0d", i), mk_in(3, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 0),
              FREEZE);
      step("mw_then_lu", mk_in(3, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 1), STALL);
      step("mw_lu_done", mk_in(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1), NORMAL);

      // MDU keeps counting through a freeze: busy still exactly 4 cycles.
      step("mfz_start", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), NORMAL);
      step("mfz_b0", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), FREEZE | BUSY);
      step("mfz_b1", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), FREEZE | BUSY);
      step("mfz_b2", idle, NORMAL | BUSY);
      step("mfz_b3", idle, NORMAL | BUSY);
      step("mfz_done", idle, NORMAL);

      // Restart while busy reloads the full latency.
      step("rs_start", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), NORMAL);
      step("rs_b0", idle, NORMAL | BUSY);
      step("rs_restart", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), NORMAL | BUSY);
      for (int i = 0; i < 4; i++)
         step($sformatf("rs_busy_%0d", i), idle, NORMAL | BUSY);
      step("rs_done", idle, NORMAL);

      // Reset in the middle of MDU_WAIT returns straight to RUN.
      step("rm_start", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), NORMAL);
      step("rm_busy", idle, NORMAL | BUSY);
      step("rm_reset", mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), RESETV, 1'b1);
      step("rm_after", mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), NORMAL);
`ifdef HAZARD_STATS_EN
      check_stats("stats_after_reset", 32'd0, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
